// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nandn_pipe.sv
// Multi-channel WIDTH-input NAND with the AND tree split over STAGES registers and valid/ready flow control.
// Optional one-entry input skid buffer: define GF180MCU_FD_SC_MCU7T5V0_NANDN_PIPE_SKID_EN.
module gf180mcu_fd_sc_mcu7t5v0__nandn_pipe #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned STAGES   = 2
) (
`ifdef USE_POWER_PINS
  inout  logic                         VDD,
  inout  logic                         VSS,
`endif
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [CHANNELS*WIDTH-1:0]    A,
  input  logic                         VLD_I,
  output logic                         RDY_O,
  output logic [CHANNELS-1:0]          ZN,
  output logic                         VLD_O,
  input  logic                         RDY_I
);

  localparam int unsigned DEPTH = $clog2(WIDTH);
  localparam int unsigned NREG  = (STAGES > 1) ? STAGES - 1 : 1;

  typedef logic [CHANNELS-1:0][WIDTH-1:0] terms_t;

  // Term j of the result ANDs input terms j*2^k .. j*2^k+2^k-1; slots with no source stay 1.
  function automatic terms_t reduce_terms(input terms_t t, input int unsigned k);
    terms_t r;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        r[c][j] = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if ((i >> k) == j) r[c][j] = r[c][j] & t[c][i];
        end
      end
    end
    return r;
  endfunction

  terms_t              in_d;
  logic                in_v;
  logic [STAGES:0]     rdy;
  logic [STAGES-1:0]   v;
  logic [STAGES:0]     v_chain;
  logic                ready_acc;
  terms_t              part_q [NREG];

`ifdef GF180MCU_FD_SC_MCU7T5V0_NANDN_PIPE_SKID_EN
  logic   skid_free;
  terms_t skid_d;

  // While the skid holds an entry it has priority into stage 0 and new input is refused.
  assign in_v  = ~skid_free | VLD_I;
  assign in_d  = skid_free ? terms_t'(A) : skid_d;
  assign RDY_O = skid_free;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      skid_free <= 1'b1;
      skid_d    <= '0;
    end else if (skid_free) begin
      if (VLD_I && !rdy[0]) begin
        skid_free <= 1'b0;
        skid_d    <= terms_t'(A);
      end
    end else if (rdy[0]) begin
      skid_free <= 1'b1;
    end
  end
`else
  assign in_v  = VLD_I;
  assign in_d  = terms_t'(A);
  assign RDY_O = rdy[0];
`endif

  // rdy[s] is high when any stage at or after s is empty, or the sink is ready.
  always_comb begin
    rdy[STAGES] = RDY_I;
    ready_acc   = RDY_I;
    for (int unsigned i = 0; i < STAGES; i++) begin
      ready_acc            = ready_acc | ~v[STAGES-1-i];
      rdy[STAGES-1-i]      = ready_acc;
    end
  end

  assign v_chain = {v, in_v};
  assign VLD_O   = v_chain[STAGES];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v <= '0;
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (rdy[s]) v[s] <= v_chain[s];
      end
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    terms_t src;

    if (s == 0) begin : g_src_in
      assign src = in_d;
    end else begin : g_src_reg
      assign src = part_q[s-1];
    end

    if (s < STAGES - 1) begin : g_part
      // Tree levels are spread evenly; stages past the tree depth reduce by 0 levels (pure delay).
      localparam int unsigned SHIFT = ((s + 1) * DEPTH) / STAGES - (s * DEPTH) / STAGES;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          part_q[s] <= '0;
        end else if (rdy[s] && v_chain[s]) begin
          part_q[s] <= reduce_terms(src, SHIFT);
        end
      end
    end else begin : g_last
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          ZN <= '1;
        end else if (rdy[s] && v_chain[s]) begin
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            ZN[c] <= ~&src[c];
          end
        end
      end
    end
  end

endmodule
